// File: rtl/irq_pkg.sv
// Shared definitions for the external interrupt controller and the machine controller.
package irq_pkg;

   localparam int unsigned ADDR_W = 6;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned ID_W   = 5;

   localparam logic [ADDR_W-1:0] PRIO_BASE = 6'h00;
   localparam logic [ADDR_W-1:0] PEND_IDX  = 6'h20;
   localparam logic [ADDR_W-1:0] EN_IDX    = 6'h21;
   localparam logic [ADDR_W-1:0] THR_IDX   = 6'h22;
   localparam logic [ADDR_W-1:0] CLAIM_IDX = 6'h23;

   localparam logic [3:0] CAUSE_MEI = 4'b1011;

   typedef enum logic [1:0] {
      GW_IDLE      = 2'd0,
      GW_PENDING   = 2'd1,
      GW_IN_FLIGHT = 2'd2
   } gw_state;

endpackage

// File: rtl/irq_gateway.sv
// Per-source gateway: latches a level line as pending and holds it off until the
// claim/complete handshake for this source has finished.
module irq_gateway
   import irq_pkg::*;
(
   input  logic    i_clk,
   input  logic    i_rst_n,
   input  logic    i_line,
   input  logic    i_claim_hit,
   input  logic    i_complete_hit,
   output logic    o_pending,
   output gw_state o_state
);

   gw_state r_state;
   logic    r_pending;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state   <= GW_IDLE;
         r_pending <= 1'b0;
      end else begin
         case (r_state)
            GW_IDLE: begin
               if (i_line) begin
                  r_state   <= GW_PENDING;
                  r_pending <= 1'b1;
               end
            end
            GW_PENDING: begin
               if (i_claim_hit) begin
                  r_state   <= GW_IN_FLIGHT;
                  r_pending <= 1'b0;
               end
            end
            GW_IN_FLIGHT: begin
               // A line still high re-pends via IDLE on the following edge.
               if (i_complete_hit) begin
                  r_state <= GW_IDLE;
               end
            end
            default: begin
               r_state   <= GW_IDLE;
               r_pending <= 1'b0;
            end
         endcase
      end
   end

   assign o_pending = r_pending;
   assign o_state   = r_state;

endmodule

// File: rtl/ext_irq_controller.sv
// External interrupt controller: gateways, priority/threshold arbitration, and the
// word-addressed register port with claim/complete at CLAIM_IDX.
module ext_irq_controller
   import irq_pkg::*;
#(
   parameter int unsigned NUM_SRC = 8,
   parameter int unsigned PRIO_W  = 3
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic [NUM_SRC-1:0]   i_irq_src,
   input  logic                 i_wr_en,
   input  logic                 i_rd_en,
   input  logic [ADDR_W-1:0]    i_addr,
   input  logic [DATA_W-1:0]    i_wdata,
   output logic [DATA_W-1:0]    o_rdata,
   output logic                 o_rvalid,
   output logic                 o_meip,
   output logic [ID_W-1:0]      o_claim_id
);

   logic [PRIO_W-1:0]  r_prio [NUM_SRC];
   logic [NUM_SRC-1:0] r_enable;
   logic [PRIO_W-1:0]  r_thr;
   logic [DATA_W-1:0]  r_rdata;
   logic               r_rvalid;
   logic               r_meip;
   logic [ID_W-1:0]    r_claim_id;

   logic [NUM_SRC-1:0] w_pending;
   logic [NUM_SRC-1:0] w_in_flight;
   logic [NUM_SRC-1:0] w_claim_hit;
   logic [NUM_SRC-1:0] w_complete_hit;
   gw_state            w_gw_state [NUM_SRC];
   logic [ID_W-1:0]    w_best_id;
   logic [PRIO_W-1:0]  w_best_prio;
   logic [DATA_W-1:0]  w_rd_data;
   logic               w_claim;
   logic               w_complete;
   logic [ID_W-1:0]    w_cpl_id;
   logic               w_unused;

   assign w_claim    = i_rd_en && (i_addr == CLAIM_IDX);
   assign w_complete = i_wr_en && (i_addr == CLAIM_IDX);
   assign w_cpl_id   = i_wdata[ID_W-1:0];
   assign w_unused   = ^i_wdata;

   // Source index g carries ID g+1; ID 0 and IDs above NUM_SRC never match.
   for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
      assign w_in_flight[g]    = (w_gw_state[g] == GW_IN_FLIGHT);
      assign w_claim_hit[g]    = w_claim && (w_best_id == ID_W'(g + 1));
      assign w_complete_hit[g] = w_complete && (w_cpl_id == ID_W'(g + 1)) && w_in_flight[g];

      irq_gateway u_gw (
         .i_clk          (i_clk),
         .i_rst_n        (i_rst_n),
         .i_line         (i_irq_src[g]),
         .i_claim_hit    (w_claim_hit[g]),
         .i_complete_hit (w_complete_hit[g]),
         .o_pending      (w_pending[g]),
         .o_state        (w_gw_state[g])
      );
   end

   // Ascending scan with strict compare: ties keep the lowest ID, threshold is the floor.
   always_comb begin
      w_best_id   = '0;
      w_best_prio = r_thr;
      for (int unsigned k = 0; k < NUM_SRC; k++) begin
         if (w_pending[k] && r_enable[k] && (r_prio[k] > w_best_prio)) begin
            w_best_prio = r_prio[k];
            w_best_id   = ID_W'(k + 1);
         end
      end
   end

   always_comb begin
      w_rd_data = '0;
      for (int unsigned k = 0; k < NUM_SRC; k++) begin
         if (i_addr == ADDR_W'(PRIO_BASE + k)) begin
            w_rd_data = DATA_W'(r_prio[k]);
         end
      end
      case (i_addr)
         PEND_IDX:  w_rd_data = DATA_W'(w_pending);
         EN_IDX:    w_rd_data = DATA_W'(r_enable);
         THR_IDX:   w_rd_data = DATA_W'(r_thr);
         CLAIM_IDX: w_rd_data = DATA_W'(w_best_id);
         default:   ;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int unsigned k = 0; k < NUM_SRC; k++) begin
            r_prio[k] <= '0;
         end
         r_enable <= '0;
         r_thr    <= '0;
      end else if (i_wr_en) begin
         for (int unsigned k = 0; k < NUM_SRC; k++) begin
            if (i_addr == ADDR_W'(PRIO_BASE + k)) begin
               r_prio[k] <= i_wdata[PRIO_W-1:0];
            end
         end
         if (i_addr == EN_IDX) begin
            r_enable <= i_wdata[NUM_SRC-1:0];
         end
         if (i_addr == THR_IDX) begin
            r_thr <= i_wdata[PRIO_W-1:0];
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_rdata    <= '0;
         r_rvalid   <= 1'b0;
         r_meip     <= 1'b0;
         r_claim_id <= '0;
      end else begin
         r_rvalid   <= i_rd_en;
         r_meip     <= (w_best_id != '0);
         r_claim_id <= w_best_id;
         if (i_rd_en) begin
            r_rdata <= w_rd_data;
         end
      end
   end

   assign o_rdata    = r_rdata;
   assign o_rvalid   = r_rvalid;
   assign o_meip     = r_meip;
   assign o_claim_id = r_claim_id;

endmodule

// File: tb/tb_ext_irq_controller.sv
// Bench for ext_irq_controller: register vectors, directed claim/complete sequences
// and random traffic, all compared against a set-based model of the controller.
module tb_ext_irq_controller;

   localparam int unsigned NUM_SRC = 8;
   localparam int unsigned PRIO_W  = 3;

   logic               clk = 1'b0;
   logic               rst_n;
   logic [NUM_SRC-1:0] irq;
   logic               wr_en;
   logic               rd_en;
   logic [5:0]         addr;
   logic [31:0]        wdata;
   logic [31:0]        rdata;
   logic               rvalid;
   logic               meip;
   logic [4:0]         claim_id;

   always #5 clk = ~clk;

   ext_irq_controller #(.NUM_SRC(NUM_SRC), .PRIO_W(PRIO_W)) dut (
      .i_clk      (clk),
      .i_rst_n    (rst_n),
      .i_irq_src  (irq),
      .i_wr_en    (wr_en),
      .i_rd_en    (rd_en),
      .i_addr     (addr),
      .i_wdata    (wdata),
      .o_rdata    (rdata),
      .o_rvalid   (rvalid),
      .o_meip     (meip),
      .o_claim_id (claim_id)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: sets of pending / in-flight IDs plus the register file.
   int m_prio [NUM_SRC];
   bit m_en   [NUM_SRC];
   bit m_pend [NUM_SRC];
   bit m_infl [NUM_SRC];
   int m_thr;
   int m_cid;
   int m_rdata;
   bit m_rvalid;

   task automatic model_reset();
      for (int k = 0; k < NUM_SRC; k++) begin
         m_prio[k] = 0; m_en[k] = 0; m_pend[k] = 0; m_infl[k] = 0;
      end
      m_thr = 0; m_cid = 0; m_rdata = 0; m_rvalid = 0;
   endtask

   // Highest priority level first, then lowest ID within that level.
   function automatic int m_best();
      int r = 0;
      for (int p = (1 << PRIO_W) - 1; p > m_thr; p--)
         for (int id = 1; id <= NUM_SRC; id++)
            if (r == 0 && m_pend[id-1] && m_en[id-1] && m_prio[id-1] == p) r = id;
      return r;
   endfunction

   function automatic int m_read(input int a, input int best);
      int v = 0;
      if (a < NUM_SRC) v = m_prio[a];
      else if (a == 'h20) begin for (int k = 0; k < NUM_SRC; k++) if (m_pend[k]) v += (1 << k); end
      else if (a == 'h21) begin for (int k = 0; k < NUM_SRC; k++) if (m_en[k]) v += (1 << k); end
      else if (a == 'h22) v = m_thr;
      else if (a == 'h23) v = best;
      return v;
   endfunction

   task automatic model_step();
      int best, cl, cp, id;
      bit np [NUM_SRC];
      bit ni [NUM_SRC];
      best = m_best();
      cl = 0; cp = 0;
      m_rvalid = rd_en;
      if (rd_en) m_rdata = m_read(int'(addr), best);
      if (rd_en && addr == 6'h23) cl = best;
      if (wr_en && addr == 6'h23) begin
         id = int'(wdata[4:0]);
         if (id >= 1 && id <= NUM_SRC && m_infl[id-1]) cp = id;
      end
      for (int k = 0; k < NUM_SRC; k++) begin
         np[k] = (m_pend[k] && cl != k + 1) || (!m_pend[k] && !m_infl[k] && irq[k]);
         ni[k] = (m_infl[k] && cp != k + 1) || (cl == k + 1);
      end
      for (int k = 0; k < NUM_SRC; k++) begin
         m_pend[k] = np[k]; m_infl[k] = ni[k];
      end
      if (wr_en) begin
         if (int'(addr) < NUM_SRC) m_prio[addr] = int'(wdata[PRIO_W-1:0]);
         if (addr == 6'h21) for (int k = 0; k < NUM_SRC; k++) m_en[k] = wdata[k];
         if (addr == 6'h22) m_thr = int'(wdata[PRIO_W-1:0]);
      end
      m_cid = best;
   endtask

   // One clock: advance the model with the driven inputs, then compare after the edge.
   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
      check("meip", 32'(meip), 32'(m_cid != 0));
      check("claim_id", 32'(claim_id), 32'(m_cid));
      check("rvalid", 32'(rvalid), 32'(m_rvalid));
      if (m_rvalid) check("rdata", rdata, 32'(m_rdata));
   endtask

   task automatic wr(input logic [5:0] a, input logic [31:0] d);
      wr_en = 1'b1; addr = a; wdata = d;
      tick();
      wr_en = 1'b0;
   endtask

   task automatic rd(input logic [5:0] a, output logic [31:0] d);
      rd_en = 1'b1; addr = a;
      tick();
      rd_en = 1'b0;
      d = rdata;
   endtask

   typedef struct {
      bit          is_wr;
      logic [5:0]  a;
      logic [31:0] d;
      logic [31:0] exp;
   } vec_t;

   vec_t        vecs [$];
   logic [31:0] d;

   initial begin
      rst_n = 1'b0; irq = '0; wr_en = 1'b0; rd_en = 1'b0; addr = '0; wdata = '0;
      model_reset();
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      check("reset_meip", 32'(meip), 32'd0);
      check("reset_rvalid", 32'(rvalid), 32'd0);
      check("reset_claim_id", 32'(claim_id), 32'd0);
      check("reset_rdata", rdata, 32'd0);

      // Register map vectors
      vecs.push_back('{0, 6'h23, 32'h0, 32'h0});          // claim with nothing pending
      vecs.push_back('{0, 6'h02, 32'h0, 32'h0});
      vecs.push_back('{1, 6'h02, 32'hFFFF_FFFD, 32'h0});  // prio ID3 = 5
      vecs.push_back('{0, 6'h02, 32'h0, 32'h5});
      vecs.push_back('{1, 6'h21, 32'hFFFF_FF04, 32'h0});  // enable ID3 only
      vecs.push_back('{0, 6'h21, 32'h0, 32'h4});
      vecs.push_back('{1, 6'h22, 32'h0000_0012, 32'h0});  // threshold = 2
      vecs.push_back('{0, 6'h22, 32'h0, 32'h2});
      vecs.push_back('{1, 6'h20, 32'hFFFF_FFFF, 32'h0});  // pending is read-only
      vecs.push_back('{0, 6'h20, 32'h0, 32'h0});
      vecs.push_back('{1, 6'h30, 32'hFFFF_FFFF, 32'h0});
      vecs.push_back('{0, 6'h30, 32'h0, 32'h0});
      vecs.push_back('{0, 6'h08, 32'h0, 32'h0});          // just past the last priority
      foreach (vecs[i]) begin
         if (vecs[i].is_wr) wr(vecs[i].a, vecs[i].d);
         else begin
            rd(vecs[i].a, d);
            check($sformatf("vec%0d_rd_%0h", i, vecs[i].a), d, vecs[i].exp);
         end
      end

      // Single source: meip two edges after the line rises, claim clears it
      irq[2] = 1'b1;
      tick();
      check("t1_meip_early", 32'(meip), 32'd0);
      tick();
      check("t1_meip", 32'(meip), 32'd1);
      check("t1_claim_id", 32'(claim_id), 32'd3);
      rd(6'h23, d);  check("t1_claim", d, 32'd3);
      rd(6'h20, d);  check("t1_pend_cleared", d, 32'h0);
      check("t1_meip_off", 32'(meip), 32'd0);
      repeat (3) tick();
      rd(6'h20, d);  check("t3_no_repend", d, 32'h0);
      wr(6'h23, 32'd4);
      rd(6'h20, d);  check("t3_bad_complete", d, 32'h0);
      wr(6'h23, 32'd3);
      tick();
      rd(6'h20, d);  check("t3_repend", d, 32'h4);
      irq = '0;
      rd(6'h23, d);  check("t3_reclaim", d, 32'd3);
      wr(6'h23, 32'd3);

      // Equal priorities: lowest ID first, then empty claim
      wr(6'h01, 32'd4); wr(6'h04, 32'd4); wr(6'h21, 32'h12); wr(6'h22, 32'd0);
      irq = 8'h12; tick(); irq = '0; tick();
      rd(6'h23, d);  check("t2_claim_a", d, 32'd2);
      rd(6'h23, d);  check("t2_claim_b", d, 32'd5);
      rd(6'h23, d);  check("t2_claim_none", d, 32'd0);
      rd(6'h20, d);  check("t2_pend", d, 32'h0);
      wr(6'h23, 32'd2); wr(6'h23, 32'd5);

      // Priority equal to threshold does not qualify
      wr(6'h22, 32'd5); wr(6'h00, 32'd5); wr(6'h21, 32'h01);
      irq = 8'h01; tick(); irq = '0; tick(); tick();
      check("t4_meip_masked", 32'(meip), 32'd0);
      rd(6'h20, d);  check("t4_pend", d, 32'h1);
      wr(6'h22, 32'd4);
      check("t4_meip_lat", 32'(meip), 32'd0);
      tick();
      check("t4_meip", 32'(meip), 32'd1);
      rd(6'h23, d);  check("t4_claim", d, 32'd1);
      wr(6'h23, 32'd1);

      // Claim of ID6 with its line rising in the same cycle
      wr(6'h22, 32'd0); wr(6'h05, 32'd3); wr(6'h21, 32'h20);
      irq = 8'h20; tick(); irq = '0; tick();
      irq = 8'h20;
      rd(6'h23, d);  check("t5_claim", d, 32'd6);
      rd(6'h20, d);  check("t5_pend_a", d, 32'h0);
      tick(); tick();
      rd(6'h20, d);  check("t5_pend_b", d, 32'h0);
      irq = '0;
      wr(6'h23, 32'd6);
      rd(6'h20, d);  check("t5_pend_c", d, 32'h0);

      // Asynchronous reset in the middle of a claim
      wr(6'h00, 32'd7); wr(6'h21, 32'hFF);
      irq = 8'h03; tick(); tick();
      rd_en = 1'b1; addr = 6'h23;
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      check("t6_meip_rst", 32'(meip), 32'd0);
      check("t6_rvalid_rst", 32'(rvalid), 32'd0);
      check("t6_claim_id_rst", 32'(claim_id), 32'd0);
      rd_en = 1'b0; irq = '0;
      @(negedge clk);
      rst_n = 1'b1;
      rd(6'h20, d);  check("t6_pend", d, 32'h0);
      rd(6'h21, d);  check("t6_en", d, 32'h0);
      rd(6'h00, d);  check("t6_prio1", d, 32'h0);
      rd(6'h02, d);  check("t6_prio3", d, 32'h0);
      check("t6_meip", 32'(meip), 32'd0);

      // Random traffic against the model
      wr(6'h21, 32'hFF);
      for (int k = 0; k < NUM_SRC; k++) wr(6'(k), 32'($urandom_range(0, 7)));
      for (int n = 0; n < 3000; n++) begin
         int sel;
         if ($urandom_range(0, 3) == 0) irq = NUM_SRC'($urandom);
         rd_en = ($urandom_range(0, 2) == 0);
         wr_en = ($urandom_range(0, 3) == 0);
         sel = $urandom_range(0, 9);
         if (sel < 4)       addr = 6'h23;
         else if (sel == 4) addr = 6'h20;
         else if (sel == 5) addr = 6'h21;
         else if (sel == 6) addr = 6'h22;
         else if (sel < 9)  addr = 6'($urandom_range(0, NUM_SRC - 1));
         else               addr = 6'($urandom_range(0, 63));
         wdata = $urandom;
         if (addr == 6'h23) wdata[4:0] = 5'($urandom_range(0, NUM_SRC + 2));
         if (addr == 6'h22) wdata[2:0] = 3'($urandom_range(0, 3));
         tick();
         rd_en = 1'b0; wr_en = 1'b0;
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
